max_pool_feeder: RTL and testbench

- Drives the 32-lane signed max-reduction tree used for max pooling; it is the producer side of that tree's `din`/`repetition`/`previous_data` interface.
- Accepts a serial element stream and packs BANK elements per chunk. Presents each chunk to the reducer and feeds the running maximum back through `previous_data`.
- Emits one pooled result per window of `cfg_chunks` chunks on a valid/ready output.

---
 rtl/max_pool_pkg.sv | 36 +++
 rtl/pool_lane_packer.sv | 76 +++++++
 rtl/max_pool_feeder.sv | 187 ++++++++++++++++++
 tb/tb_max_pool_feeder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_pool_pkg.sv
`default_nettype none
// ============================================================================
// Module : max_pool_pkg
// Purpose: Shared types and constants for the max-pool feeder.
//          - state_e        : feeder FSM state encoding
//          - REP_*          : repetition codes driven to the max-reduction tree
//          - signed_min()   : most negative two's complement value of a width
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package max_pool_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL    = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_OUTPUT  = 2'd3
   } state_e;

   // Repetition codes understood by the reducer. REP_FIRST makes the reducer
   // register load MIN; any other code makes it load pool_prev.
   localparam logic [1:0] REP_FIRST = 2'b00;
   localparam logic [1:0] REP_MID   = 2'b01;
   localparam logic [1:0] REP_LAST  = 2'b10;

   localparam int unsigned MAX_DW = 64;

   // Only the sign bit set: the identity element of a signed max.
   function automatic logic [MAX_DW-1:0] signed_min(input int unsigned dw);
      logic [MAX_DW-1:0] one;
      one        = {{(MAX_DW-1){1'b0}}, 1'b1};
      signed_min = one << (dw - 1);
   endfunction

endpackage : max_pool_pkg
`default_nettype wire

// File: rtl/pool_lane_packer.sv
`default_nettype none
// ============================================================================
// Module : pool_lane_packer
// Purpose: Lane counter plus BANK-lane register file. Each write stores the
//          element in the lane addressed by the counter and advances it; the
//          counter wraps to 0 after the last lane.
// Ports  : clk_i      - clock
//          rstn_i     - asynchronous active-low reset
//          clr_i      - restart packing at lane 0
//          wr_en_i    - write wr_data_i into the current lane
//          wr_data_i  - element to store
//          lanes_o    - packed lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//          lane_cnt_o - current lane index
//          full_o     - current lane is the last one (next write completes)
// Rev    : 1.0  initial release
// ============================================================================
module pool_lane_packer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BANK       = 32,
   parameter int unsigned LANE_W     = (BANK > 1) ? $clog2(BANK) : 1
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       clr_i,
   input  logic                       wr_en_i,
   input  logic [DATA_WIDTH-1:0]      wr_data_i,
   output logic [DATA_WIDTH*BANK-1:0] lanes_o,
   output logic [LANE_W-1:0]          lane_cnt_o,
   output logic                       full_o
);

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BANK - 1);

   logic [LANE_W-1:0] lane_cnt_q;
   logic [LANE_W-1:0] lane_cnt_d;
   logic              w_full;

   assign w_full = (lane_cnt_q == LAST_LANE);

   always_comb begin
      lane_cnt_d = lane_cnt_q;
      if (clr_i) begin
         lane_cnt_d = '0;
      end else if (wr_en_i) begin
         lane_cnt_d = w_full ? '0 : lane_cnt_q + LANE_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         lane_cnt_q <= '0;
      end else begin
         lane_cnt_q <= lane_cnt_d;
      end
   end

   // One register per lane; only the addressed lane captures the element.
   for (genvar i = 0; i < BANK; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_q;

      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            lane_q <= '0;
         end else if (wr_en_i && !clr_i && (lane_cnt_q == LANE_W'(i))) begin
            lane_q <= wr_data_i;
         end
      end

      assign lanes_o[i*DATA_WIDTH +: DATA_WIDTH] = lane_q;
   end : g_lane

   assign lane_cnt_o = lane_cnt_q;
   assign full_o     = w_full;

endmodule : pool_lane_packer
`default_nettype wire

// File: rtl/max_pool_feeder.sv
`default_nettype none
// ============================================================================
// Module : max_pool_feeder
// Purpose: Producer side of the 32-lane signed max-reduction tree. Packs a
//          serial element stream into BANK-wide chunks, presents each chunk
//          to the reducer with the matching repetition code, feeds the
//          running maximum back through pool_prev and emits one pooled result
//          per window of cfg_chunks chunks on a valid/ready port.
// Ports  : clk, rstn            - clock, asynchronous active-low reset
//          start, cfg_chunks    - window start pulse and chunks per window
//          busy                 - window in progress
//          s_valid/s_data/s_ready - element input stream
//          pool_din/pool_rep/pool_prev - drive to reducer
//          pool_dout            - reducer result
//          m_valid/m_data/m_ready - pooled result stream
// Rev    : 1.0  initial release
// ============================================================================
module max_pool_feeder
   import max_pool_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BANK       = 32,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       start,
   input  logic [CNT_W-1:0]           cfg_chunks,
   output logic                       busy,
   input  logic                       s_valid,
   input  logic [DATA_WIDTH-1:0]      s_data,
   output logic                       s_ready,
   output logic [DATA_WIDTH*BANK-1:0] pool_din,
   output logic [1:0]                 pool_rep,
   output logic [DATA_WIDTH-1:0]      pool_prev,
   input  logic [DATA_WIDTH-1:0]      pool_dout,
   output logic                       m_valid,
   output logic [DATA_WIDTH-1:0]      m_data,
   input  logic                       m_ready
);

   localparam logic [DATA_WIDTH-1:0] MIN_VAL = DATA_WIDTH'(signed_min(DATA_WIDTH));
   localparam int unsigned LANE_W = (BANK > 1) ? $clog2(BANK) : 1;

   state_e                  state_q,     state_d;
   logic [CNT_W-1:0]        chunks_q,    chunks_d;
   logic [CNT_W-1:0]        chunk_cnt_q, chunk_cnt_d;
   logic [DATA_WIDTH-1:0]   acc_q,       acc_d;
   logic                    m_valid_q,   m_valid_d;
   logic [DATA_WIDTH-1:0]   m_data_q,    m_data_d;

   logic                    w_pk_clr;
   logic                    w_pk_wr;
   logic                    w_pk_full;
   logic [LANE_W-1:0]       w_lane_cnt;
   logic                    w_first_chunk;
   logic                    w_last_chunk;
   logic [1:0]              w_chunk_rep;

   // -------------------------------------------------------------------------
   // Chunk packing
   // -------------------------------------------------------------------------
   pool_lane_packer #(
      .DATA_WIDTH (DATA_WIDTH),
      .BANK       (BANK),
      .LANE_W     (LANE_W)
   ) u_packer (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .clr_i      (w_pk_clr),
      .wr_en_i    (w_pk_wr),
      .wr_data_i  (s_data),
      .lanes_o    (pool_din),
      .lane_cnt_o (w_lane_cnt),
      .full_o     (w_pk_full)
   );

   // -------------------------------------------------------------------------
   // Repetition code for the chunk currently being filled / computed. The
   // first chunk always uses REP_FIRST so the reducer starts from MIN even
   // when the window has a single chunk.
   // -------------------------------------------------------------------------
   assign w_first_chunk = (chunk_cnt_q == '0);
   assign w_last_chunk  = (chunk_cnt_q == (chunks_q - CNT_W'(1)));

   always_comb begin
      w_chunk_rep = REP_MID;
      if (w_first_chunk) begin
         w_chunk_rep = REP_FIRST;
      end else if (w_last_chunk) begin
         w_chunk_rep = REP_LAST;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next-state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      chunks_d    = chunks_q;
      chunk_cnt_d = chunk_cnt_q;
      acc_d       = acc_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      busy        = 1'b1;
      s_ready     = 1'b0;
      pool_rep    = REP_FIRST;
      w_pk_clr    = 1'b0;
      w_pk_wr     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d     = ST_FILL;
               chunks_d    = (cfg_chunks == '0) ? CNT_W'(1) : cfg_chunks;
               chunk_cnt_d = '0;
               w_pk_clr    = 1'b1;
            end
         end

         ST_FILL: begin
            s_ready  = 1'b1;
            pool_rep = w_chunk_rep;
            w_pk_wr  = s_valid;
            // The packer wraps its lane counter itself on the last lane.
            if (s_valid && w_pk_full) begin
               state_d = ST_COMPUTE;
            end
         end

         ST_COMPUTE: begin
            pool_rep    = w_chunk_rep;
            acc_d       = pool_dout;
            chunk_cnt_d = chunk_cnt_q + CNT_W'(1);
            if (w_last_chunk) begin
               m_data_d  = pool_dout;
               m_valid_d = 1'b1;
               state_d   = ST_OUTPUT;
            end else begin
               state_d   = ST_FILL;
            end
         end

         ST_OUTPUT: begin
            // start is not looked at here, so a start coincident with the
            // accept is dropped.
            if (m_ready) begin
               m_valid_d = 1'b0;
               acc_d     = MIN_VAL;
               state_d   = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         chunks_q    <= CNT_W'(1);
         chunk_cnt_q <= '0;
         acc_q       <= MIN_VAL;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         chunks_q    <= chunks_d;
         chunk_cnt_q <= chunk_cnt_d;
         acc_q       <= acc_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
      end
   end

   assign pool_prev = acc_q;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;

endmodule : max_pool_feeder
`default_nettype wire

// File: tb/tb_max_pool_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_max_pool_feeder
// Purpose: Directed self-checking bench for max_pool_feeder. Includes a
//          behavioural model of the 32-lane max-reduction tree and its
//          repetition register so the feeder runs in closed loop.
// Rev    : 1.0  initial release
// ============================================================================
module tb_max_pool_feeder;

   localparam int DW   = 8;
   localparam int BANK = 32;
   localparam int CW   = 8;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 start;
   logic [CW-1:0]        cfg_chunks;
   logic                 busy;
   logic                 s_valid;
   logic [DW-1:0]        s_data;
   logic                 s_ready;
   logic [DW*BANK-1:0]   pool_din;
   logic [1:0]           pool_rep;
   logic [DW-1:0]        pool_prev;
   logic [DW-1:0]        pool_dout;
   logic                 m_valid;
   logic [DW-1:0]        m_data;
   logic                 m_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] chunk_v [BANK];

   always #5 clk = ~clk;

   max_pool_feeder #(
      .DATA_WIDTH (DW),
      .BANK       (BANK),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .cfg_chunks (cfg_chunks),
      .busy       (busy),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .pool_din   (pool_din),
      .pool_rep   (pool_rep),
      .pool_prev  (pool_prev),
      .pool_dout  (pool_dout),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready)
   );

   // Reducer model: register loads MIN on rep==00, else pool_prev.
   logic [DW-1:0] red_q = 8'h80;
   always @(posedge clk) red_q <= (pool_rep == 2'b00) ? 8'h80 : pool_prev;

   function automatic logic [DW-1:0] tree_max(input logic [DW*BANK-1:0] din,
                                              input logic [DW-1:0] r);
      logic [DW-1:0] m;
      m = r;
      for (int i = 0; i < BANK; i++)
         if ($signed(din[i*DW +: DW]) > $signed(m)) m = din[i*DW +: DW];
      return m;
   endfunction

   assign pool_dout = tree_max(pool_din, red_q);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_win(input logic [CW-1:0] n);
      start      = 1'b1;
      cfg_chunks = n;
      tick();
      start      = 1'b0;
   endtask

   task automatic send_elem(input logic [DW-1:0] d);
      int n;
      n       = 0;
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && n < 200) begin
         tick();
         n++;
      end
      if (!s_ready) begin
         check("s_ready_timeout", 32'(s_ready), 32'd1);
         s_valid = 1'b0;
         return;
      end
      tick();
      s_valid = 1'b0;
   endtask

   // Sends lanes lo..hi of chunk_v; random idle gaps between elements only.
   task automatic send_range(input int lo, input int hi, input int max_gap);
      for (int i = lo; i <= hi; i++) begin
         send_elem(chunk_v[i]);
         if (i < BANK - 1 && max_gap > 0)
            repeat ($urandom_range(0, max_gap)) tick();
      end
   endtask

   task automatic fill_chunk(input logic [DW-1:0] base, input int idx, input logic [DW-1:0] v);
      for (int i = 0; i < BANK; i++) chunk_v[i] = base;
      chunk_v[idx] = v;
   endtask

   task automatic wait_mvalid(input string tag);
      int n;
      n = 0;
      while (!m_valid && n < 300) begin
         tick();
         n++;
      end
      check(tag, 32'(m_valid), 32'd1);
   endtask

   task automatic accept();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   initial begin
      logic stable;
      rstn = 1'b0; start = 1'b0; cfg_chunks = '0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      repeat (3) tick();

      // Reset values
      check("rst_busy",    32'(busy),            32'd0);
      check("rst_s_ready", 32'(s_ready),         32'd0);
      check("rst_m_valid", 32'(m_valid),         32'd0);
      check("rst_m_data",  32'(m_data),          32'h00);
      check("rst_din",     32'(pool_din == '0),  32'd1);
      check("rst_rep",     32'(pool_rep),        32'd0);
      check("rst_prev",    32'(pool_prev),       32'h80);
      rstn = 1'b1;
      tick();

      // Single chunk, max at lane 17
      start_win(8'd1);
      check("t1_busy",    32'(busy),    32'd1);
      check("t1_s_ready", 32'(s_ready), 32'd1);
      fill_chunk(8'hF0, 17, 8'h7F);
      send_range(0, BANK - 1, 0);
      // now in the single compute cycle
      check("t1_cmp_s_ready", 32'(s_ready),           32'd0);
      check("t1_cmp_rep",     32'(pool_rep),          32'd0);
      check("t1_lane17",      32'(pool_din[17*DW +: DW]), 32'h7F);
      check("t1_lane0",       32'(pool_din[0 +: DW]),  32'hF0);
      check("t1_cmp_mvalid",  32'(m_valid),           32'd0);
      tick();
      check("t1_mvalid", 32'(m_valid),  32'd1);
      check("t1_mdata",  32'(m_data),   32'h7F);
      check("t1_out_rep",32'(pool_rep), 32'd0);
      accept();
      check("t1_drop",   32'(m_valid),   32'd0);
      check("t1_idle",   32'(busy),      32'd0);
      check("t1_prev",   32'(pool_prev), 32'h80);

      // All-minimum
      start_win(8'd1);
      fill_chunk(8'h80, 0, 8'h80);
      send_range(0, BANK - 1, 0);
      wait_mvalid("t2_mvalid");
      check("t2_mdata", 32'(m_data), 32'h80);
      accept();

      // Three chunks: -5, 0x12, -100
      start_win(8'd3);
      check("t3_rep0", 32'(pool_rep), 32'd0);
      fill_chunk(8'hEC, 7, 8'hFB);
      send_range(0, BANK - 1, 0);
      tick();
      check("t3_rep1",  32'(pool_rep),  32'd1);
      check("t3_prev1", 32'(pool_prev), 32'hFB);
      fill_chunk(8'hCE, 3, 8'h12);
      send_range(0, BANK - 1, 0);
      check("t3_cmp1_mvalid", 32'(m_valid), 32'd0);
      tick();
      check("t3_rep2",  32'(pool_rep),  32'd2);
      check("t3_prev2", 32'(pool_prev), 32'h12);
      fill_chunk(8'h9C, 0, 8'h9C);
      send_range(0, BANK - 1, 0);
      check("t3_cmp2_rep", 32'(pool_rep), 32'd2);
      tick();
      check("t3_mvalid", 32'(m_valid),  32'd1);
      check("t3_mdata",  32'(m_data),   32'h12);
      check("t3_outrep", 32'(pool_rep), 32'd0);
      accept();

      // Stalls on both sides: chunk0 = i-40 (max -9), chunk1 all -60
      start_win(8'd2);
      for (int i = 0; i < BANK; i++) chunk_v[i] = 8'(i - 40);
      send_range(0, BANK - 1, 3);
      fill_chunk(8'hC4, 0, 8'hC4);
      send_range(0, BANK - 1, 3);
      wait_mvalid("t4_mvalid");
      check("t4_mdata", 32'(m_data), 32'hF7);
      s_valid = 1'b1;
      s_data  = 8'h7F;
      stable  = 1'b1;
      repeat (5) begin
         tick();
         if (!(m_valid && m_data == 8'hF7 && !s_ready)) stable = 1'b0;
      end
      check("t4_stall_hold", 32'(stable), 32'd1);
      accept();
      check("t4_drop",   32'(m_valid), 32'd0);
      check("t4_idle",   32'(busy),    32'd0);
      check("t4_idle_sr",32'(s_ready), 32'd0);
      tick();
      check("t4_no_second", 32'(m_valid), 32'd0);
      s_valid = 1'b0;

      // Mid-window reset after 10 elements
      start_win(8'd1);
      fill_chunk(8'h7F, 0, 8'h7F);
      send_range(0, 9, 0);
      #2 rstn = 1'b0;
      #1;
      check("t5_busy",    32'(busy),           32'd0);
      check("t5_s_ready", 32'(s_ready),        32'd0);
      check("t5_din",     32'(pool_din == '0), 32'd1);
      check("t5_prev",    32'(pool_prev),      32'h80);
      check("t5_mvalid",  32'(m_valid),        32'd0);
      tick();
      rstn = 1'b1;
      tick();
      start_win(8'd1);
      fill_chunk(8'h01, 5, 8'h33);
      send_range(0, BANK - 1, 0);
      wait_mvalid("t5_mvalid2");
      check("t5_mdata", 32'(m_data), 32'h33);
      accept();

      // cfg_chunks = 0 behaves as 1
      start_win(8'd0);
      fill_chunk(8'h01, 9, 8'h21);
      send_range(0, BANK - 1, 0);
      tick();
      check("t6_zero_mvalid", 32'(m_valid), 32'd1);
      check("t6_zero_mdata",  32'(m_data),  32'h21);
      accept();

      // start during FILL is ignored
      start_win(8'd2);
      fill_chunk(8'h05, 0, 8'h05);
      send_range(0, 4, 0);
      start_win(8'd1);
      send_range(5, BANK - 1, 0);
      tick();
      check("t6_ign_mvalid", 32'(m_valid), 32'd0);
      check("t6_ign_fill",   32'(s_ready), 32'd1);
      fill_chunk(8'h80, 31, 8'h44);
      send_range(0, BANK - 1, 0);
      wait_mvalid("t6_ign_mvalid2");
      check("t6_ign_mdata", 32'(m_data), 32'h44);
      // start coincident with accept is dropped
      start      = 1'b1;
      cfg_chunks = 8'd1;
      accept();
      start      = 1'b0;
      check("t6_coinc_busy", 32'(busy), 32'd0);
      tick();
      check("t6_coinc_busy2", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_max_pool_feeder
`default_nettype wire
